// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffer entry layout
// and the default reset PC.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO holding fetched {word, pc} entries; flush empties it and
// overrides any push or pop in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != {CW{1'b0}});
  assign count_o = count_q;

  // Storage, pointers and occupancy; the pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake and feeds decode.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          misalign_q, misalign_d;

  logic          redir_s, bad_s, pop_s, push_s, flush_s;
  logic          space_idle_s, space_push_s;
  logic [31:0]   rpc_s, next_pc_s;
  logic [CW-1:0] count_s, after_pop_s;
  fetch_entry_t  head_s, push_data_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign rpc_s = redirect_pc;
  assign bad_s = (redirect_pc[1:0] != 2'b00);
`else
  assign rpc_s = redirect_pc & 32'hFFFF_FFFC;
  assign bad_s = 1'b0;
`endif

  assign redir_s      = redirect_valid && (state_q != HALT);
  assign flush_s      = redir_s;
  assign pop_s        = inst_valid && inst_ready && !redir_s;
  assign after_pop_s  = count_s - {{(CW-1){1'b0}}, pop_s};
  // A new request reserves one slot for its response on top of what is left after this cycle.
  assign space_idle_s = (after_pop_s < CW'(BUF_DEPTH));
  assign space_push_s = (after_pop_s < CW'(BUF_DEPTH - 1));
  assign next_pc_s    = redir_s ? rpc_s : fetch_pc_q;
  assign push_data_s  = '{word: imem_rdata, pc: addr_q};

  fetch_buffer #(.DEPTH(BUF_DEPTH), .CW(CW)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .flush_i    (flush_s),
    .push_data_i(push_data_s),
    .head_o     (head_s),
    .valid_o    (inst_valid),
    .count_o    (count_s)
  );

  assign inst      = head_s.word;
  assign inst_pc   = head_s.pc;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign misalign  = misalign_q;

  // Next-state logic; req/addr only move when no request is left unacknowledged.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    misalign_d = misalign_q;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (redir_s) begin
          fetch_pc_d = rpc_s;
          if (bad_s) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = rpc_s;
          end
        end else if (space_idle_s) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redir_s) begin
          fetch_pc_d = rpc_s;
          if (bad_s) begin
            misalign_d = 1'b1;
            state_d    = HALT;
            req_d      = !imem_ack;
          end else if (imem_ack) begin
            state_d = REQ;
            addr_d  = rpc_s;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ack) begin
          push_s     = 1'b1;
          fetch_pc_d = addr_q + 32'd4;
          if (space_push_s) begin
            state_d = REQ;
            addr_d  = addr_q + 32'd4;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else begin
          state_d = REQ;
        end
      end
      DROP: begin
        fetch_pc_d = next_pc_s;
        if (redir_s && bad_s) begin
          misalign_d = 1'b1;
          state_d    = HALT;
          req_d      = !imem_ack;
        end else if (imem_ack) begin
          state_d = REQ;
          addr_d  = next_pc_s;
        end else begin
          state_d = DROP;
        end
      end
      HALT: begin
        if (req_q && imem_ack) begin
          req_d = 1'b0;
        end else begin
          req_d = req_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= 32'h0000_0000;
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue of expected {word, pc} entries
// is filled on kept acks and compared against the decode-side head each cycle.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] sb[$];
  logic        exp_mis = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs, drive inputs, update the expected buffer, advance.
  task automatic step(input logic a, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic er, input logic [31:0] ea, input logic keep);
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    if (er) chk("imem_addr", imem_addr, ea);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, (sb.size() != 0)});
    chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    if (sb.size() != 0) begin
      chk("inst", inst, sb[0][63:32]);
      chk("inst_pc", inst_pc, sb[0][31:0]);
    end
    imem_ack       = a;
    imem_rdata     = a ? word_of(ea) : 32'd0;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && rdy) void'(sb.pop_front());
      if (a && er && keep) sb.push_back({word_of(ea), ea});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // streaming, one word per cycle
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h4, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h8, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hC, 1'b1);
    // decode stalls: buffer fills, request stops, then resumes
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h14, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h14, 1'b1);
    // redirect while waiting for ack: old response dropped, address held
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h18, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h104, 1'b1);
    // redirect coinciding with ack
    step(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h104, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 1'b1);
    // address wrap at the top of memory
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h200, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h4, 1'b1);
    // redirect from IDLE with a full buffer
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h300, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h304, 1'b1);
    // misaligned redirect target
    step(1'b0, 1'b1, 1'b1, 32'h102, 1'b1, 32'h304, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_mis = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h304, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
`else
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h304, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h104, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h104, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the instruction control decoder. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, buffers returned words in a small FIFO, and presents them with their PC to decode over a valid/ready interface. Control-flow redirects (taken jal/jalr/beq/blt, resolved downstream) flush the buffer and restart fetch at the target.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, 2: fetch buffer entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  32  word address of the outstanding request; registered, stable while `imem_req`=1.
- `imem_ack`  in  1  completes the request in the cycle `imem_req`&&`imem_ack`.
- `imem_rdata`  in  32  instruction word, valid in the completing cycle.
- `redirect_valid`  in  1  single-cycle redirect strobe.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  buffer non-empty.
- `inst_ready`  in  1  decode accepts head entry.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  PC of head instruction.
- `misalign`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- FSM states: IDLE (no request outstanding), REQ (request outstanding, response kept), DROP (request outstanding, response discarded), HALT (fetch stopped).
- At most one outstanding request. Issue only when `count + 1 ≤ BUF_DEPTH` after this cycle's pop; buffer therefore never overflows.
- IDLE→REQ when space: `imem_req`←1, `imem_addr`←`fetch_pc`.
- REQ on ack: push {`imem_rdata`, `imem_addr`}; `fetch_pc`←`imem_addr`+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); REQ again if space else IDLE.
- `imem_req` and `imem_addr` never change while a request is unacknowledged, including across redirects.
- Redirect (any state but HALT): buffer count→0, `fetch_pc`←`redirect_pc`. In REQ without ack → DROP. In REQ with ack same cycle → response discarded, → REQ at `redirect_pc`. In IDLE → REQ at `redirect_pc`.
- DROP on ack: discard response; → REQ at `fetch_pc`. Redirect in DROP only updates `fetch_pc`.
- Pop when `inst_valid`&&`inst_ready`; a pop coinciding with a redirect is void (flush wins).
- Reset values: `imem_req`=0, `imem_addr`=0, `inst_valid`=0, `misalign`=0, `fetch_pc`=`RESET_PC`, state IDLE, count 0. Reset mid-transaction abandons it; any late ack after reset is not expected and is ignored in IDLE.

## Timing
- First `imem_req` in the first cycle after `rst_n` rises, address `RESET_PC`.
- Ack in cycle M → `inst_valid` in M+1 (push latency 1); back-to-back acks sustain 1 instr/cycle when decode is ready.
- Redirect in cycle N with no outstanding request → `imem_req`, `imem_addr`=`redirect_pc` in N+1; `inst_valid`=0 in N+1.
- `inst`, `inst_pc` are registered FIFO head, stable while `inst_valid`&&!`inst_ready`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `misalign`=1, flushes, enters HALT (outstanding response still absorbed); only reset leaves HALT.
- Undefined: `redirect_pc[1:0]` forced to 0; `misalign` tied 0; HALT unreachable.

## Structure
- Package `fetch_pkg`: FSM state enum, `RESET_PC` default, buffer entry struct {word, pc}.
- Sub-module `fetch_buffer`: circular FIFO, depth `BUF_DEPTH`, push/pop/flush, count output; flush overrides simultaneous push/pop.

## Test plan
- Reset release, ack held 1, `inst_ready`=1 → addresses 0,4,8,… each cycle; `inst_pc` lags `imem_addr` by one cycle.
- `inst_ready`=0, ack held 1 → exactly `BUF_DEPTH` words buffered, `imem_req` then drops to 0; raising `inst_ready` resumes without loss.
- Redirect to 32'h0000_0100 while request for 0x8 awaits ack (ack 3 cycles later) → 0x8 word discarded, `imem_addr` stays 0x8 until ack, next request 0x100, first `inst_pc`=0x100.
- Redirect and ack same cycle → response dropped, next cycle `imem_addr`=`redirect_pc`, buffer empty.
- `fetch_pc`=32'hFFFF_FFFC fetched → next address 0.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 32'h0000_0102 → `misalign`=1 next cycle, no further `imem_req`; without macro, fetch proceeds at 0x100.
